ascon_dec_seq: RTL and testbench

- Sequencer for the ASCON-128 ciphertext-processing phase of decryption.
- Holds the 320-bit state (x0..x4) and streams 64-bit ciphertext blocks in over a valid/ready handshake.
- For each block it emits the plaintext, writes the ciphertext into the rate, then drives an external single-round permutation unit for NROUNDS cycles.
- Sits between the init/AD stage, which loads the state, and the finalization stage, which consumes the state output.

---
 rtl/ascon_dec_seq.sv | 127 ++++++++++++
 tb/tb_ascon_dec_seq.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ascon_dec_seq.sv
// ascon_dec_seq: ASCON-128 decryption ciphertext-phase sequencer (optional partial last block via ASCON_DEC_SEQ_PARTIAL_EN)
module ascon_dec_seq #(
  parameter int NROUNDS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_load,
  input  logic [63:0] st_in0,
  input  logic [63:0] st_in1,
  input  logic [63:0] st_in2,
  input  logic [63:0] st_in3,
  input  logic [63:0] st_in4,
  input  logic        ct_valid,
  output logic        ct_ready,
  input  logic [63:0] ct_data,
  input  logic        ct_last,
`ifdef ASCON_DEC_SEQ_PARTIAL_EN
  input  logic [3:0]  ct_bytes,
`endif
  output logic        pt_valid,
  input  logic        pt_ready,
  output logic [63:0] pt_data,
  output logic        pt_last,
  output logic [63:0] rnd_x0,
  output logic [63:0] rnd_x1,
  output logic [63:0] rnd_x2,
  output logic [63:0] rnd_x3,
  output logic [63:0] rnd_x4,
  output logic [7:0]  rnd_rc,
  input  logic [63:0] rnd_y0,
  input  logic [63:0] rnd_y1,
  input  logic [63:0] rnd_y2,
  input  logic [63:0] rnd_y3,
  input  logic [63:0] rnd_y4,
  output logic [63:0] st_out0,
  output logic [63:0] st_out1,
  output logic [63:0] st_out2,
  output logic [63:0] st_out3,
  output logic [63:0] st_out4,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, WAIT_CT, EMIT, PERM, DONE} st_e;
  st_e              st_q;
  logic [4:0][63:0] x_q;
  logic [4:0][63:0] y;
  logic [63:0]      pt_data_q, m, pad, pt_d, x0_d;
  logic [3:0]       r_q, k, n;
  logic [6:0]       sh;
  logic             last_q, ct_ready_q, pt_valid_q, pt_last_q, done_q;

  assign y = {rnd_y4, rnd_y3, rnd_y2, rnd_y1, rnd_y0};
  assign {rnd_x4, rnd_x3, rnd_x2, rnd_x1, rnd_x0} = x_q;
  assign {st_out4, st_out3, st_out2, st_out1, st_out0} = x_q;
  assign ct_ready = ct_ready_q;
  assign pt_valid = pt_valid_q;
  assign pt_data  = pt_data_q;
  assign pt_last  = pt_last_q;
  assign done     = done_q;
  assign k        = 4'(12 - NROUNDS) + r_q;
  assign rnd_rc   = (st_q == PERM) ? {4'hF - k, k} : 8'h00;

  // Byte mask of valid ciphertext bytes and the 0x80 pad byte for a short last block
  always_comb begin
`ifdef ASCON_DEC_SEQ_PARTIAL_EN
    n = ct_last ? ct_bytes : 4'd8;
`else
    n = 4'd8;
`endif
    sh   = {n, 3'b000};
    m    = ~(64'hFFFF_FFFF_FFFF_FFFF >> sh);
    pad  = (n < 4'd8) ? (64'h80 << (7'd56 - sh)) : 64'h0;
    pt_d = (x_q[0] ^ ct_data) & m;
    x0_d = ((ct_data & m) | (x_q[0] & ~m)) ^ pad;
  end

  // Sequencer FSM with registered handshake outputs and the state datapath
  always_ff @(posedge clk)
    if (rst) begin
      st_q       <= IDLE;
      x_q        <= '0;
      pt_data_q  <= '0;
      r_q        <= '0;
      last_q     <= 1'b0;
      ct_ready_q <= 1'b0;
      pt_valid_q <= 1'b0;
      pt_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (st_q)
        IDLE:
          if (st_load) begin
            x_q        <= {st_in4, st_in3, st_in2, st_in1, st_in0};
            ct_ready_q <= 1'b1;
            st_q       <= WAIT_CT;
          end
        WAIT_CT:
          if (ct_valid) begin
            pt_data_q  <= pt_d;
            x_q[0]     <= x0_d;
            pt_last_q  <= ct_last;
            last_q     <= ct_last;
            ct_ready_q <= 1'b0;
            pt_valid_q <= 1'b1;
            st_q       <= EMIT;
          end
        EMIT:
          if (pt_ready) begin
            pt_valid_q <= 1'b0;
            pt_last_q  <= 1'b0;
            r_q        <= '0;
            done_q     <= last_q;
            st_q       <= last_q ? DONE : PERM;
          end
        PERM: begin
          x_q <= y;
          r_q <= r_q + 4'd1;
          if (r_q == 4'(NROUNDS - 1)) begin
            ct_ready_q <= 1'b1;
            st_q       <= WAIT_CT;
          end
        end
        DONE:    st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ascon_dec_seq.sv
// tb_ascon_dec_seq: directed self-checking bench for ascon_dec_seq with a +1-per-lane stub round unit
module tb_ascon_dec_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_load = 1'b0;
  logic [63:0] st_in0 = '0, st_in1 = '0, st_in2 = '0, st_in3 = '0, st_in4 = '0;
  logic        ct_valid = 1'b0, ct_last = 1'b0, pt_ready = 1'b0;
  logic [63:0] ct_data = '0;
  logic        ct_ready, pt_valid, pt_last, done;
  logic [63:0] pt_data;
  logic [63:0] rnd_x0, rnd_x1, rnd_x2, rnd_x3, rnd_x4;
  logic [63:0] rnd_y0, rnd_y1, rnd_y2, rnd_y3, rnd_y4;
  logic [63:0] st_out0, st_out1, st_out2, st_out3, st_out4;
  logic [7:0]  rnd_rc;
  logic [63:0] held;
  logic [7:0]  rc_exp [6] = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  int          checks = 0;
  int          errors = 0;
`ifdef ASCON_DEC_SEQ_PARTIAL_EN
  logic [3:0]  ct_bytes = 4'd8;
`endif

  ascon_dec_seq #(.NROUNDS(6)) dut (
    .clk(clk), .rst(rst), .st_load(st_load),
    .st_in0(st_in0), .st_in1(st_in1), .st_in2(st_in2), .st_in3(st_in3), .st_in4(st_in4),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .ct_last(ct_last),
`ifdef ASCON_DEC_SEQ_PARTIAL_EN
    .ct_bytes(ct_bytes),
`endif
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .pt_last(pt_last),
    .rnd_x0(rnd_x0), .rnd_x1(rnd_x1), .rnd_x2(rnd_x2), .rnd_x3(rnd_x3), .rnd_x4(rnd_x4),
    .rnd_rc(rnd_rc),
    .rnd_y0(rnd_y0), .rnd_y1(rnd_y1), .rnd_y2(rnd_y2), .rnd_y3(rnd_y3), .rnd_y4(rnd_y4),
    .st_out0(st_out0), .st_out1(st_out1), .st_out2(st_out2), .st_out3(st_out3), .st_out4(st_out4),
    .done(done)
  );

  assign rnd_y0 = rnd_x0 + 64'd1;
  assign rnd_y1 = rnd_x1 + 64'd1;
  assign rnd_y2 = rnd_x2 + 64'd1;
  assign rnd_y3 = rnd_x3 + 64'd1;
  assign rnd_y4 = rnd_x4 + 64'd1;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_ct_ready", ct_ready, 0);
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_x0", st_out0, 0);
    chk("rst_rc", rnd_rc, 0);
    st_in0 = 64'h0123_4567_89AB_CDEF; st_in1 = 64'd1; st_in2 = 64'd2; st_in3 = 64'd3; st_in4 = 64'd4;
    st_load = 1'b1;
    step();
    st_load = 1'b0;
    chk("load_ct_ready", ct_ready, 1);
    chk("load_x0", st_out0, 64'h0123_4567_89AB_CDEF);
    chk("load_x4", st_out4, 64'd4);
    ct_valid = 1'b1; ct_data = 64'hFFFF_FFFF_FFFF_FFFF; ct_last = 1'b0; pt_ready = 1'b0;
    step();
    chk("b0_pt_valid", pt_valid, 1);
    chk("b0_pt_data", pt_data, 64'hFEDC_BA98_7654_3210);
    chk("b0_pt_last", pt_last, 0);
    chk("b0_x0", st_out0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("b0_ct_ready", ct_ready, 0);
    repeat (10) step();
    chk("bp_pt_data", pt_data, 64'hFEDC_BA98_7654_3210);
    chk("bp_pt_valid", pt_valid, 1);
    chk("bp_ct_ready", ct_ready, 0);
    chk("bp_x0", st_out0, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("bp_x1", st_out1, 64'd1);
    chk("bp_rc", rnd_rc, 0);
    ct_valid = 1'b0; pt_ready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("perm%0d_rc", i), rnd_rc, rc_exp[i]);
      chk($sformatf("perm%0d_x0", i), st_out0, 64'hFFFF_FFFF_FFFF_FFFF + 64'(i));
      chk($sformatf("perm%0d_pt_valid", i), pt_valid, 0);
      chk($sformatf("perm%0d_ct_ready", i), ct_ready, 0);
      step();
    end
    chk("post_ct_ready", ct_ready, 1);
    chk("post_rc", rnd_rc, 0);
    chk("post_x0", st_out0, 64'd5);
    chk("post_x1", st_out1, 64'd7);
    chk("post_x4", st_out4, 64'd10);
    ct_valid = 1'b1; ct_data = 64'h1111_2222_3333_4444; ct_last = 1'b1;
    step();
    ct_valid = 1'b0; ct_last = 1'b0;
    chk("b1_pt_valid", pt_valid, 1);
    chk("b1_pt_last", pt_last, 1);
    chk("b1_pt_data", pt_data, 64'h1111_2222_3333_4441);
    chk("b1_done_early", done, 0);
    step();
    chk("b1_done", done, 1);
    chk("b1_pt_valid_off", pt_valid, 0);
    chk("b1_x0", st_out0, 64'h1111_2222_3333_4444);
    chk("b1_x1", st_out1, 64'd7);
    st_in0 = 64'hDEAD_BEEF_DEAD_BEEF; st_load = 1'b1;
    step();
    st_load = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_x0_kept", st_out0, 64'h1111_2222_3333_4444);
    chk("idle_ct_ready", ct_ready, 0);
    st_in0 = 64'hA5A5_A5A5_A5A5_A5A5; st_load = 1'b1;
    step();
    st_load = 1'b0;
    ct_valid = 1'b1; ct_data = 64'h5A5A_5A5A_5A5A_5A5A; ct_last = 1'b1;
    step();
    ct_valid = 1'b0; ct_last = 1'b0;
    chk("sb_pt_data", pt_data, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sb_rc", rnd_rc, 0);
    chk("sb_done_early", done, 0);
    step();
    chk("sb_done", done, 1);
    chk("sb_x0", st_out0, 64'h5A5A_5A5A_5A5A_5A5A);
    chk("sb_rc_done", rnd_rc, 0);
    step();
    chk("sb_done_off", done, 0);
`ifdef ASCON_DEC_SEQ_PARTIAL_EN
    st_in0 = 64'h0; st_load = 1'b1;
    step();
    st_load = 1'b0;
    ct_valid = 1'b1; ct_data = 64'hAABB_CC00_0000_0000; ct_last = 1'b1; ct_bytes = 4'd3;
    step();
    ct_valid = 1'b0; ct_last = 1'b0; ct_bytes = 4'd8;
    chk("part_pt_data", pt_data, 64'hAABB_CC00_0000_0000);
    chk("part_x0", st_out0, 64'hAABB_CC80_0000_0000);
    step();
    step();
`endif
    st_in0 = 64'h0123_4567_89AB_CDEF; st_load = 1'b1;
    step();
    st_load = 1'b0;
    ct_valid = 1'b1; ct_data = 64'h0F0F_0F0F_0F0F_0F0F; ct_last = 1'b0;
    step();
    ct_valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("mid_rc3", rnd_rc, 8'h69);
    held = st_out0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ct_ready", ct_ready, 0);
    chk("mrst_pt_valid", pt_valid, 0);
    chk("mrst_pt_data", pt_data, 0);
    chk("mrst_x0", st_out0, 0);
    chk("mrst_rc", rnd_rc, 0);
    step();
    chk("mrst_idle_ct_ready", ct_ready, 0);
    chk("mrst_idle_x0", st_out0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
